// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the data-side memory responder: IO page decode,
// register offsets and TXSTAT bit layout.
package arm_mem_pkg;

  localparam logic [15:0] IO_PAGE    = 16'hFFFF;

  localparam logic [15:0] GPIO_OFS   = 16'h0000;
  localparam logic [15:0] CYCLE_OFS  = 16'h0004;
  localparam logic [15:0] TXDATA_OFS = 16'h0008;
  localparam logic [15:0] TXSTAT_OFS = 16'h000C;

  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int CNT_LSB   = 2;
  localparam int CNT_W     = 6;
  localparam int OVF_BIT   = 8;

endpackage

// File: rtl/mem_io_responder_if.sv
// Core load/store port plus the transmit byte stream and GPIO pins.
// Tx handshake: a byte moves when TxValid && TxReady on a rising clk edge;
// TxValid/TxData stay stable until that edge, and TxReady may be anything.
interface mem_io_responder_if;

  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] GpioOut;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output MemWrite, Adr, WriteData, TxReady,
    input  ReadData, GpioOut, TxData, TxValid
  );

  modport slave (
    input  MemWrite, Adr, WriteData, TxReady,
    output ReadData, GpioOut, TxData, TxValid
  );

endinterface

// File: rtl/mem_io_responder_tx_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is still accepted when the
// head is popped on the same edge.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     accepted,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign accepted = push && (!full || do_pop);
  // Stale entries are masked so the head reads zero whenever nothing is queued.
  assign head     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({accepted, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Data-side responder for the single-cycle core: word RAM plus an IO page
// with GPIO, a free-running cycle counter and a transmit FIFO.
module mem_io_responder
  import arm_mem_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int TX_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_io_responder_if.slave  bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   gpio;
  logic [31:0]   cycle;
  logic          ovf;

  logic          io_sel;
  logic [15:0]   ofs;
  logic [AW-1:0] idx;
  logic          io_wr;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_accepted;
  logic [CW-1:0] tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          unused_adr_bits;

  // Byte lanes do not exist on this port: the low two address bits never decode.
  assign unused_adr_bits = ^bus.Adr[1:0];

  assign io_sel  = (bus.Adr[31:16] == IO_PAGE);
  assign ofs     = {bus.Adr[15:2], 2'b00};
  assign idx     = bus.Adr[AW+1:2];
  assign io_wr   = bus.MemWrite && io_sel;
  assign tx_push = io_wr && (ofs == TXDATA_OFS);
  assign tx_pop  = bus.TxValid && bus.TxReady;

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (tx_push),
    .push_data (bus.WriteData[7:0]),
    .pop       (tx_pop),
    .accepted  (tx_accepted),
    .head      (bus.TxData),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign bus.TxValid = !tx_empty;
  assign bus.GpioOut = gpio;

  // RAM has no reset so its contents survive a mid-run reset pulse.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && !io_sel) ram[idx] <= bus.WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio  <= '0;
      cycle <= '0;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (io_wr && (ofs == GPIO_OFS)) gpio <= bus.WriteData;
      // A dropped byte outranks a clear request on the same edge.
      if (tx_push && !tx_accepted)
        ovf <= 1'b1;
      else if (io_wr && (ofs == TXSTAT_OFS) && bus.WriteData[OVF_BIT])
        ovf <= 1'b0;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (io_sel) begin
      case (ofs)
        GPIO_OFS:   bus.ReadData = gpio;
        CYCLE_OFS:  bus.ReadData = cycle;
        TXSTAT_OFS: begin
          bus.ReadData[FULL_BIT]             = tx_full;
          bus.ReadData[EMPTY_BIT]            = tx_empty;
          bus.ReadData[CNT_LSB +: CNT_W]     = CNT_W'(tx_count);
          bus.ReadData[OVF_BIT]              = ovf;
        end
        default:    bus.ReadData = '0;
      endcase
    end else begin
      bus.ReadData = ram[idx];
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: reset state, RAM, GPIO, IO decode,
// transmit FIFO fill/overflow/drain and mid-run reset.
module tb_mem_io_responder;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         m_cnt = 0;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .RAM_WORDS (64),
    .TX_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks; each store consumes exactly one rising edge
  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.Adr       = adr;
    bus.WriteData = data;
    @(posedge clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    bus.Adr = adr;
    #1;
    check(tag, bus.ReadData, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (m_cnt < 4) begin
      exp_q.push_back(b);
      m_cnt++;
    end
    store(32'hFFFF_0008, {24'h0, b});
  endtask

  initial begin
    reset         = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Adr       = '0;
    bus.WriteData = '0;
    bus.TxReady   = 1'b0;

    // reset state
    @(negedge clk);
    #1;
    check("rst_gpio", bus.GpioOut, 32'h0);
    check("rst_txvalid", {31'h0, bus.TxValid}, 32'h0);
    check("rst_txdata", {24'h0, bus.TxData}, 32'h0);
    load_check("rst_cycle", 32'hFFFF_0004, 32'h0);
    load_check("rst_txstat", 32'hFFFF_000C, 32'h002);

    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    load_check("idle_cycle", 32'hFFFF_0004, 32'd10);
    check("idle_txvalid", {31'h0, bus.TxValid}, 32'h0);
    load_check("idle_txstat", 32'hFFFF_000C, 32'h002);

    // RAM
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_unaligned", 32'h0000_0013, 32'hDEAD_BEEF);
    load_check("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    store(32'h0000_0014, 32'h0123_4567);
    load_check("ram_neighbor", 32'h0000_0014, 32'h0123_4567);
    load_check("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

    // GPIO and IO decode
    check("gpio_pre", bus.GpioOut, 32'h0);
    store(32'hFFFF_0000, 32'h0000_00A5);
    check("gpio_out", bus.GpioOut, 32'hA5);
    load_check("gpio_rd", 32'hFFFF_0000, 32'hA5);
    load_check("gpio_rd_unaligned", 32'hFFFF_0001, 32'hA5);
    load_check("io_other_rd", 32'hFFFF_0010, 32'h0);
    load_check("txdata_rd", 32'hFFFF_0008, 32'h0);
    store(32'hFFFF_0010, 32'hFFFF_FFFF);
    check("io_other_wr", bus.GpioOut, 32'hA5);

    // FIFO fill past capacity
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    check("fill_txvalid", {31'h0, bus.TxValid}, 32'h1);
    check("fill_head", {24'h0, bus.TxData}, 32'h11);
    load_check("fill_txstat", 32'hFFFF_000C, 32'h111);

    // drain
    bus.TxReady = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      check("drain_valid", {31'h0, bus.TxValid}, 32'h1);
      check("drain_data", {24'h0, bus.TxData}, {24'h0, exp_q.pop_front()});
      @(posedge clk);
      #1;
    end
    m_cnt = 0;
    bus.TxReady = 1'b0;
    check("drain_done", {31'h0, bus.TxValid}, 32'h0);
    load_check("drain_txstat", 32'hFFFF_000C, 32'h102);

    // full FIFO with simultaneous push and pop
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    load_check("refill_txstat", 32'hFFFF_000C, 32'h111);
    bus.TxReady = 1'b1;
    store(32'hFFFF_0008, 32'h0000_0066);
    bus.TxReady = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h66);
    load_check("simul_txstat", 32'hFFFF_000C, 32'h111);
    check("simul_head", {24'h0, bus.TxData}, {24'h0, exp_q[0]});

    store(32'hFFFF_000C, 32'h0000_00FF);
    load_check("ovf_keep", 32'hFFFF_000C, 32'h111);
    store(32'hFFFF_000C, 32'h0000_0100);
    load_check("ovf_clear", 32'hFFFF_000C, 32'h011);

    // pop one so three remain, then reset mid-drain
    bus.TxReady = 1'b1;
    @(posedge clk);
    #1;
    bus.TxReady = 1'b0;
    void'(exp_q.pop_front());
    check("three_head", {24'h0, bus.TxData}, {24'h0, exp_q[0]});
    load_check("three_txstat", 32'hFFFF_000C, 32'h00C);

    bus.TxReady = 1'b1;
    reset = 1'b0;
    #1;
    check("midrst_txvalid", {31'h0, bus.TxValid}, 32'h0);
    check("midrst_txdata", {24'h0, bus.TxData}, 32'h0);
    check("midrst_gpio", bus.GpioOut, 32'h0);
    load_check("midrst_txstat", 32'hFFFF_000C, 32'h002);
    load_check("midrst_cycle", 32'hFFFF_0004, 32'h0);
    exp_q.delete();
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.TxReady = 1'b0;
    #1;
    load_check("rel_cycle0", 32'hFFFF_0004, 32'h0);
    @(posedge clk);
    #1;
    load_check("rel_cycle1", 32'hFFFF_0004, 32'h1);
    store(32'hFFFF_0004, 32'h1234_5678);
    load_check("cycle_ro", 32'hFFFF_0004, 32'h2);
    load_check("rel_txstat", 32'hFFFF_000C, 32'h002);
    check("rel_txvalid", {31'h0, bus.TxValid}, 32'h0);
    load_check("ram_after_rst", 32'h0000_0010, 32'hDEAD_BEEF);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
